// File: rtl/multicycle_control_fsm.sv
// Main sequencer of a multicycle RV32I core: walks each instruction through fetch, decode,
// execute, memory and write-back, and drives datapath selects, enables and the ALUOp class.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic                 bcond,
  input  logic                 halt_req,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 wb_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 alu_out_write,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_R    = 2'b01;
  localparam logic [1:0] ALUOP_BR   = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALUOP_ADD;
    alu_out_write = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alu_src_b     = SRC_B_FOUR;
        alu_out_write = 1'b1;
        state_d       = S_EX;
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_R;
            alu_out_write = 1'b1;
            state_d       = S_WB;
          end
          OP_I: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRC_B_IMM;
            alu_op        = ALUOP_I;
            alu_out_write = 1'b1;
            state_d       = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRC_B_IMM;
            alu_out_write = 1'b1;
            state_d       = S_MEM;
          end
          OP_BR: begin
            // ALUOut still holds PC+4 from decode, so not-taken reuses it as next PC
            alu_src_a = 1'b1;
            alu_op    = ALUOP_BR;
            if (bcond) begin
              state_d = S_BR;
            end else begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = S_IF;
            end
          end
          OP_JAL: begin
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            state_d   = S_IF;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            state_d   = S_IF;
          end
          OP_SYS: begin
            if (halt_req) begin
              state_d = S_HALT;
            end else begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = S_IF;
            end
          end
          default: begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            state_d   = S_IF;
          end
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b = SRC_B_FOUR;
            pc_write  = 1'b1;
            state_d   = S_IF;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD);
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_BR: begin
        alu_src_b = SRC_B_IMM;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    // An ECALL that halts never pulses pc_write, so its retirement is counted on HALT entry
    cnt_d = cnt_q;
    if (pc_write || (state_q == S_EX && state_d == S_HALT)) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Datapath must see no strobes while the core is held in reset
    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_RS2;
      alu_op        = ALUOP_ADD;
      alu_out_write = 1'b0;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;

endmodule
